vec_fifo: RTL and testbench

- Parametrised synchronous FIFO for the vector engine (layernorm and neighbouring datapaths). It buffers LANES×WIDTH-bit vector words between producer and consumer stages.
- Adds the following over the basic FIFO:
  - correct simultaneous read/write;
  - write-through-when-full if a read occurs in the same cycle;
  - almost-full and almost-empty thresholds;
  - occupancy output;
  - synchronous flush;
  - sticky overflow/underflow error flags;
  - a dout_valid strobe.

---
 rtl/vec_fifo.sv | 135 +++++++++++++
 tb/tb_vec_fifo.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_fifo.sv
// vec_fifo: LANES x WIDTH vector FIFO with thresholds, flush and sticky errors.
// Define VEC_FIFO_FWFT_EN for first-word-fall-through read mode.
module vec_fifo #(
    parameter int DEPTH    = 16,
    parameter int WIDTH    = 8,
    parameter int LANES    = 1,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [LANES*WIDTH-1:0]   din,
    input  logic                     rd_en,
    output logic [LANES*WIDTH-1:0]   dout,
    output logic                     dout_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow,
    input  logic                     clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = LANES * WIDTH;

    logic [DW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic          r_underflow;

    logic w_rd_acc;
    logic w_wr_acc;
    logic w_ovf_set;
    logic w_udf_set;

    assign full         = (r_count == CW'(DEPTH));
    assign empty        = (r_count == '0);
    assign almost_full  = (r_count >= CW'(AF_LEVEL));
    assign almost_empty = (r_count <= CW'(AE_LEVEL));
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // A write into a full FIFO is allowed when a read frees a slot this cycle
    assign w_rd_acc  = rd_en & ~empty;
    assign w_wr_acc  = wr_en & (~full | w_rd_acc);
    assign w_ovf_set = wr_en & ~w_wr_acc & ~flush;
    assign w_udf_set = rd_en & empty & ~flush;

    // Storage array, not reset; flush drops the pending write
    always_ff @(posedge clk) begin
        if (!flush && w_wr_acc) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            unique case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; a new event beats clr_err
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (clr_err) begin
                r_overflow <= 1'b0;
            end
            if (w_udf_set) begin
                r_underflow <= 1'b1;
            end else if (clr_err) begin
                r_underflow <= 1'b0;
            end
        end
    end

`ifdef VEC_FIFO_FWFT_EN
    assign dout       = r_mem[r_rd_ptr];
    assign dout_valid = ~empty;
`else
    logic [DW-1:0] r_dout;
    logic          r_dout_valid;

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;

    // Registered read port: one-cycle latency, data held between pops
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else if (flush) begin
            r_dout_valid <= 1'b0;
        end else if (w_rd_acc) begin
            r_dout       <= r_mem[r_rd_ptr];
            r_dout_valid <= 1'b1;
        end else begin
            r_dout_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_vec_fifo.sv
// tb_vec_fifo: directed checks of vec_fifo at DEPTH=4, LANES=2, WIDTH=8.
// Covers ordering, full write-through, errors, flush, wrap and reset.
module tb_vec_fifo;

    logic        clk;
    logic        rstn;
    logic        flush;
    logic        wr_en;
    logic [15:0] din;
    logic        rd_en;
    logic [15:0] dout;
    logic        dout_valid;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic [2:0]  count;
    logic        overflow;
    logic        underflow;
    logic        clr_err;

    int checks = 0;
    int errors = 0;

    vec_fifo #(
        .DEPTH    (4),
        .WIDTH    (8),
        .LANES    (2),
        .AF_LEVEL (3),
        .AE_LEVEL (1)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .flush        (flush),
        .wr_en        (wr_en),
        .din          (din),
        .rd_en        (rd_en),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .clr_err      (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        flush   = 1'b0;
        clr_err = 1'b0;
        din     = '0;
    endtask

    task automatic fill4(input logic [15:0] base);
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1;
            din   = base + 16'(i);
            step();
        end
        idle();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            rd_en = 1'b1;
            step();
        end
        idle();
    endtask

    initial begin
        logic [15:0] held;
        idle();
        rstn = 1'b0;
        #12;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_aempty", 32'(almost_empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_dvalid", 32'(dout_valid), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_udf", 32'(underflow), 0);
        rstn = 1'b1;
        step();

`ifdef VEC_FIFO_FWFT_EN
        wr_en = 1'b1;
        din   = 16'h1111;
        step();
        idle();
        chk("fwft_dout", 32'(dout), 32'h1111);
        chk("fwft_dvalid", 32'(dout_valid), 1);
        chk("fwft_count", 32'(count), 1);
        step();
        chk("fwft_hold", 32'(dout), 32'h1111);
        rd_en = 1'b1;
        step();
        idle();
        chk("fwft_empty", 32'(empty), 1);
        chk("fwft_dvalid0", 32'(dout_valid), 0);
        chk("fwft_udf", 32'(underflow), 0);
`else
        // Ordered fill then drain
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1;
            din   = {8'(2 * i + 1), 8'(2 * i)};
            step();
            chk("t1_cnt_up", 32'(count), 32'(i + 1));
            chk("t1_af", 32'(almost_full), 32'(i >= 2));
            chk("t1_full", 32'(full), 32'(i == 3));
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            rd_en = 1'b1;
            step();
            chk("t1_dout", 32'(dout), 32'({8'(2 * i + 1), 8'(2 * i)}));
            chk("t1_dvalid", 32'(dout_valid), 1);
            chk("t1_cnt_dn", 32'(count), 32'(3 - i));
            chk("t1_ae", 32'(almost_empty), 32'(i >= 2));
        end
        idle();
        step();
        chk("t1_dvalid0", 32'(dout_valid), 0);
        chk("t1_empty", 32'(empty), 1);
        chk("t1_dhold", 32'(dout), 32'h0706);

        // Write-through when full
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1;
            din   = {8'(2 * i + 1), 8'(2 * i)};
            step();
        end
        wr_en = 1'b1;
        rd_en = 1'b1;
        din   = 16'h0A0B;
        step();
        idle();
        chk("t2_dout", 32'(dout), 32'h0100);
        chk("t2_count", 32'(count), 4);
        chk("t2_ovf", 32'(overflow), 0);
        rd_en = 1'b1;
        step();
        chk("t2_r1", 32'(dout), 32'h0302);
        step();
        chk("t2_r2", 32'(dout), 32'h0504);
        step();
        chk("t2_r3", 32'(dout), 32'h0706);
        step();
        chk("t2_last", 32'(dout), 32'h0A0B);
        chk("t2_empty", 32'(empty), 1);
        idle();

        // Error flags
        fill4(16'h2000);
        wr_en = 1'b1;
        step();
        idle();
        chk("t3_cnt_full", 32'(count), 4);
        chk("t3_ovf", 32'(overflow), 1);
        drain(4);
        step();
        rd_en = 1'b1;
        step();
        idle();
        chk("t3_udf", 32'(underflow), 1);
        chk("t3_udf_dv", 32'(dout_valid), 0);
        chk("t3_udf_cnt", 32'(count), 0);
        clr_err = 1'b1;
        step();
        idle();
        chk("t3_clr_ovf", 32'(overflow), 0);
        chk("t3_clr_udf", 32'(underflow), 0);
        fill4(16'h3000);
        wr_en   = 1'b1;
        clr_err = 1'b1;
        step();
        idle();
        chk("t3_set_wins", 32'(overflow), 1);
        chk("t3_udf_clr", 32'(underflow), 0);

        // Flush with concurrent write and read
        rd_en = 1'b1;
        step();
        idle();
        chk("t4_pre_dout", 32'(dout), 32'h3000);
        chk("t4_pre_cnt", 32'(count), 3);
        held  = dout;
        flush = 1'b1;
        wr_en = 1'b1;
        rd_en = 1'b1;
        din   = 16'hDEAD;
        step();
        idle();
        chk("t4_count", 32'(count), 0);
        chk("t4_empty", 32'(empty), 1);
        chk("t4_dvalid", 32'(dout_valid), 0);
        chk("t4_dhold", 32'(dout), 32'(held));
        chk("t4_ovf_kept", 32'(overflow), 1);
        chk("t4_udf_kept", 32'(underflow), 0);
        wr_en = 1'b1;
        din   = 16'h5A5A;
        step();
        idle();
        chk("t4_resume_cnt", 32'(count), 1);
        rd_en = 1'b1;
        step();
        idle();
        chk("t4_resume_dout", 32'(dout), 32'h5A5A);

        // Wrap-around with gaps between pairs
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1;
            din   = 16'(i);
            step();
            idle();
            if (i[0]) step();
            rd_en = 1'b1;
            step();
            idle();
            chk("t5_dout", 32'(dout), 32'(i));
            chk("t5_dvalid", 32'(dout_valid), 1);
            chk("t5_count", 32'(count), 0);
            if (i[1]) step();
        end

        // Asynchronous reset mid-stream
        wr_en = 1'b1;
        din   = 16'h0077;
        step();
        wr_en = 1'b1;
        din   = 16'h0088;
        rd_en = 1'b1;
        step();
        chk("t5_pre_dv", 32'(dout_valid), 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("t5_rst_dv", 32'(dout_valid), 0);
        chk("t5_rst_dout", 32'(dout), 0);
        chk("t5_rst_cnt", 32'(count), 0);
        chk("t5_rst_empty", 32'(empty), 1);
        chk("t5_rst_ovf", 32'(overflow), 0);
        idle();
        #10;
        rstn = 1'b1;
        step();
        chk("t5_post_cnt", 32'(count), 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
